// File: rtl/contour_bin_reader_pkg.sv
// Shared video constants for the contour writer/reader pair: frame geometry,
// bin-label format, result field widths and the reader FSM state type.
package contour_bin_reader_pkg;

    localparam int FRAME_WIDTH  = 640;
    localparam int FRAME_HEIGHT = 480;
    localparam int BIN_W        = 3;
    localparam int NUM_BINS     = 7;

    // 19 bits cover 640*480-1 addresses and a full-frame count of 307200;
    // 28 bits cover the largest coordinate sum (98150400).
    localparam int ADDR_W  = 19;
    localparam int COUNT_W = 19;
    localparam int SUM_W   = 28;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        EMIT,
        DONE
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/contour_bin_reader_bin_accumulator.sv
// Per-bin register file: pixel count, sum of x and sum of y for bins 1..7.
// Entry 0 is the "no contour" label and is never written.
module bin_accumulator
    import contour_bin_reader_pkg::*;
#(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               add_en,
    input  logic [BIN_W-1:0]   add_bin,
    input  logic [X_W-1:0]     add_x,
    input  logic [Y_W-1:0]     add_y,
    input  logic [BIN_W-1:0]   rd_bin,
    output logic [COUNT_W-1:0] rd_count,
    output logic [SUM_W-1:0]   rd_sum_x,
    output logic [SUM_W-1:0]   rd_sum_y
);

    localparam int ENTRIES = 2 ** BIN_W;

    logic [COUNT_W-1:0] count_q [ENTRIES];
    logic [SUM_W-1:0]   sum_x_q [ENTRIES];
    logic [SUM_W-1:0]   sum_y_q [ENTRIES];

    // Clear on reset or frame start; otherwise add one labelled pixel per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                count_q[i] <= '0;
                sum_x_q[i] <= '0;
                sum_y_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < ENTRIES; i++) begin
                count_q[i] <= '0;
                sum_x_q[i] <= '0;
                sum_y_q[i] <= '0;
            end
        end else if (add_en && (add_bin != '0)) begin
            count_q[add_bin] <= count_q[add_bin] + COUNT_W'(1);
            sum_x_q[add_bin] <= sum_x_q[add_bin] + SUM_W'(add_x);
            sum_y_q[add_bin] <= sum_y_q[add_bin] + SUM_W'(add_y);
        end
    end

    assign rd_count = count_q[rd_bin];
    assign rd_sum_x = sum_x_q[rd_bin];
    assign rd_sum_y = sum_y_q[rd_bin];

endmodule

// File: rtl/contour_bin_reader.sv
// Scans a bin-label BRAM in raster order, accumulates count/sum_x/sum_y per
// bin and then hands the seven per-bin results out over a valid/ready port.
module contour_bin_reader
    import contour_bin_reader_pkg::*;
#(
    parameter int WIDTH        = FRAME_WIDTH,
    parameter int HEIGHT       = FRAME_HEIGHT,
    parameter int READ_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  bram_addr,
    input  logic [BIN_W-1:0]   bram_read,
    output logic               busy,
    output logic               done,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [BIN_W-1:0]   result_bin,
    output logic [COUNT_W-1:0] result_count,
    output logic [SUM_W-1:0]   result_sum_x,
    output logic [SUM_W-1:0]   result_sum_y
);

    localparam int X_W   = coord_w(WIDTH);
    localparam int Y_W   = coord_w(HEIGHT);
    localparam int LAT_W = coord_w(READ_LATENCY);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [X_W-1:0]    LAST_X     = X_W'(WIDTH - 1);
    localparam logic [LAT_W-1:0]  LAST_DRAIN = LAT_W'(READ_LATENCY - 1);
    localparam logic [BIN_W-1:0]  LAST_BIN   = BIN_W'(NUM_BINS);

    state_t state, state_nxt;
    logic   start_acc;
    logic   emit_load;
    logic   emit_last;

    logic [X_W-1:0]   x_p0;
    logic [Y_W-1:0]   y_p0;
    logic             vld_p0;
    logic [X_W-1:0]   x_pd [1:READ_LATENCY];
    logic [Y_W-1:0]   y_pd [1:READ_LATENCY];
    logic [READ_LATENCY:1] vld_pd;
    logic [LAT_W-1:0] drain_cnt;

    logic               acc_add;
    logic [BIN_W-1:0]   rd_bin;
    logic [COUNT_W-1:0] rd_count;
    logic [SUM_W-1:0]   rd_sum_x;
    logic [SUM_W-1:0]   rd_sum_y;

    assign vld_p0  = (state == SCAN);
    assign busy    = (state == SCAN) || (state == DRAIN) || (state == EMIT);
    assign done    = (state == DONE);
    assign acc_add = vld_pd[READ_LATENCY] && (bram_read != '0);
    assign rd_bin  = result_bin + BIN_W'(1);

    // A result is loaded when the output slot is empty or being drained,
    // except after bin 7, whose acceptance ends the frame.
    assign emit_last = (state == EMIT) && result_valid && result_ready && (result_bin == LAST_BIN);
    assign emit_load = (state == EMIT) && (!result_valid || (result_ready && (result_bin != LAST_BIN)));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; start is only honoured when not busy.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN:    if (bram_addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == LAST_DRAIN) state_nxt = EMIT;
            EMIT:    if (emit_last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Raster address and x/y counters; the drain counter waits out the BRAM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bram_addr <= '0;
            x_p0      <= '0;
            y_p0      <= '0;
            drain_cnt <= '0;
        end else if (start_acc) begin
            bram_addr <= '0;
            x_p0      <= '0;
            y_p0      <= '0;
            drain_cnt <= '0;
        end else if ((state == SCAN) && (bram_addr != LAST_ADDR)) begin
            bram_addr <= bram_addr + ADDR_W'(1);
            if (x_p0 == LAST_X) begin
                x_p0 <= '0;
                y_p0 <= y_p0 + Y_W'(1);
            end else begin
                x_p0 <= x_p0 + X_W'(1);
            end
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + LAT_W'(1);
        end
    end

    // Sample-valid flags travelling with the outstanding BRAM reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pd <= '0;
        end else begin
            vld_pd[1] <= vld_p0;
            for (int i = 2; i <= READ_LATENCY; i++) vld_pd[i] <= vld_pd[i-1];
        end
    end

    // Coordinates delayed to line up with the returning bin label.
    always_ff @(posedge clk) begin
        x_pd[1] <= x_p0;
        y_pd[1] <= y_p0;
        for (int i = 2; i <= READ_LATENCY; i++) begin
            x_pd[i] <= x_pd[i-1];
            y_pd[i] <= y_pd[i-1];
        end
    end

    bin_accumulator #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_bin_accumulator (
        .clk      (clk),
        .reset    (reset),
        .clr      (start_acc),
        .add_en   (acc_add),
        .add_bin  (bram_read),
        .add_x    (x_pd[READ_LATENCY]),
        .add_y    (y_pd[READ_LATENCY]),
        .rd_bin   (rd_bin),
        .rd_count (rd_count),
        .rd_sum_x (rd_sum_x),
        .rd_sum_y (rd_sum_y)
    );

    // Registered result slot; the next bin is loaded on the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid <= 1'b0;
            result_bin   <= '0;
            result_count <= '0;
            result_sum_x <= '0;
            result_sum_y <= '0;
        end else if (start_acc) begin
            result_valid <= 1'b0;
            result_bin   <= '0;
            result_count <= '0;
            result_sum_x <= '0;
            result_sum_y <= '0;
        end else if (emit_load) begin
            result_valid <= 1'b1;
            result_bin   <= rd_bin;
            result_count <= rd_count;
            result_sum_x <= rd_sum_x;
            result_sum_y <= rd_sum_y;
        end else if (emit_last) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contour_bin_reader.sv
// Directed bench for contour_bin_reader on a 16x8 frame with a 2-cycle BRAM.
module tb_contour_bin_reader;
    import contour_bin_reader_pkg::*;

    localparam int W   = 16;
    localparam int H   = 8;
    localparam int RL  = 2;
    localparam int N   = W * H;
    localparam int LAT = N + RL + 1;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               result_ready = 1'b1;
    logic [ADDR_W-1:0]  bram_addr;
    logic [BIN_W-1:0]   bram_read;
    logic               busy;
    logic               done;
    logic               result_valid;
    logic [BIN_W-1:0]   result_bin;
    logic [COUNT_W-1:0] result_count;
    logic [SUM_W-1:0]   result_sum_x;
    logic [SUM_W-1:0]   result_sum_y;

    logic [2:0] mem [0:N-1];
    logic [2:0] rd_q1 = '0;
    logic [2:0] rd_q2 = '0;

    int n_checks = 0;
    int n_errs   = 0;
    int exp_c [1:7];
    int exp_x [1:7];
    int exp_y [1:7];

    contour_bin_reader #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .READ_LATENCY (RL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bram_addr    (bram_addr),
        .bram_read    (bram_read),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_bin   (result_bin),
        .result_count (result_count),
        .result_sum_x (result_sum_x),
        .result_sum_y (result_sum_y)
    );

    always #5 clk = ~clk;

    // Two-cycle synchronous BRAM model.
    always @(posedge clk) begin
        rd_q1 <= (bram_addr < ADDR_W'(N)) ? mem[bram_addr[6:0]] : 3'd0;
        rd_q2 <= rd_q1;
    end
    assign bram_read = rd_q2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int b = 1; b <= 7; b++) begin
            exp_c[b] = 0;
            exp_x[b] = 0;
            exp_y[b] = 0;
        end
    endtask

    task automatic fill_mem(input logic [2:0] v);
        for (int i = 0; i < N; i++) mem[i] = v;
    endtask

    task automatic check_fields(input string pfx, input int b);
        check($sformatf("%s bin%0d valid", pfx, b), 64'(result_valid), 64'(1));
        check($sformatf("%s bin%0d id", pfx, b), 64'(result_bin), 64'(b));
        check($sformatf("%s bin%0d count", pfx, b), 64'(result_count), 64'(exp_c[b]));
        check($sformatf("%s bin%0d sum_x", pfx, b), 64'(result_sum_x), 64'(exp_x[b]));
        check($sformatf("%s bin%0d sum_y", pfx, b), 64'(result_sum_y), 64'(exp_y[b]));
    endtask

    task automatic run_frame(input string name, input bit second_start, input bit stall);
        int lat;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({name, " busy_after_start"}, 64'(busy), 64'(1));
        check({name, " done_after_start"}, 64'(done), 64'(0));
        check({name, " valid_after_start"}, 64'(result_valid), 64'(0));
        lat = 0;
        while (!result_valid && lat < LAT + 50) begin
            @(negedge clk);
            lat++;
            start = (second_start && lat == 40);
        end
        start = 1'b0;
        check({name, " latency"}, 64'(lat), 64'(LAT));
        for (int b = 1; b <= 7; b++) begin
            check_fields(name, b);
            if (stall && b == 1) begin
                result_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_fields({name, " stall"}, b);
                end
                result_ready = 1'b1;
            end
            @(negedge clk);
        end
        check({name, " done_end"}, 64'(done), 64'(1));
        check({name, " busy_end"}, 64'(busy), 64'(0));
        check({name, " valid_end"}, 64'(result_valid), 64'(0));
    endtask

    initial begin
        int k;
        fill_mem(3'd0);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst bram_addr", 64'(bram_addr), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst valid", 64'(result_valid), 64'(0));
        check("rst bin", 64'(result_bin), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // All-zero frame: every bin reports zero.
        clear_exp();
        run_frame("zero", 1'b0, 1'b0);

        // Single label 3 at x=10, y=5 (address 90).
        fill_mem(3'd0);
        mem[90] = 3'd3;
        clear_exp();
        exp_c[3] = 1; exp_x[3] = 10; exp_y[3] = 5;
        run_frame("single", 1'b0, 1'b0);

        // Whole frame labelled 7: 128 px, sum_x = 8*120, sum_y = 16*28.
        fill_mem(3'd7);
        clear_exp();
        exp_c[7] = 128; exp_x[7] = 960; exp_y[7] = 448;
        run_frame("full7", 1'b0, 1'b0);

        // Corners and row-wrap pixels, with a five-cycle stall on bin 1.
        fill_mem(3'd0);
        mem[0] = 3'd1; mem[127] = 3'd1;
        mem[15] = 3'd2; mem[16] = 3'd2;
        mem[35] = 3'd5; mem[36] = 3'd5;
        clear_exp();
        exp_c[1] = 2; exp_x[1] = 15; exp_y[1] = 7;
        exp_c[2] = 2; exp_x[2] = 15; exp_y[2] = 1;
        exp_c[5] = 2; exp_x[5] = 7;  exp_y[5] = 4;
        run_frame("mixed_stall", 1'b0, 1'b1);

        // Same frame with a second start pulse mid-scan.
        run_frame("restart_ignored", 1'b1, 1'b0);

        // Reset in the middle of a scan, then a fresh frame.
        fill_mem(3'd4);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (bram_addr != ADDR_W'(100) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("midscan addr", 64'(bram_addr), 64'(100));
        reset = 1'b1;
        #1;
        check("midscan rst addr", 64'(bram_addr), 64'(0));
        check("midscan rst busy", 64'(busy), 64'(0));
        check("midscan rst valid", 64'(result_valid), 64'(0));
        check("midscan rst done", 64'(done), 64'(0));
        check("midscan rst bin", 64'(result_bin), 64'(0));
        check("midscan rst count", 64'(result_count), 64'(0));
        @(negedge clk) reset = 1'b0;
        fill_mem(3'd0);
        mem[50] = 3'd6;
        clear_exp();
        exp_c[6] = 1; exp_x[6] = 2; exp_y[6] = 3;
        run_frame("after_reset", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/contour_bin_reader.md
CONTOUR_BIN_READER -- requirements
Module: contour_bin_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 640, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 480, frame height in pixels.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from bram_addr change to valid bram_read.
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, pulse that begins one frame scan.
REQ-007 SHALL have port bram_addr, output, 19, raster read address into the 3-bit bin-label BRAM.
REQ-008 SHALL have port bram_read, input, 3, bin label at bram_addr, READ_LATENCY cycles late; 0 = no contour.
REQ-009 SHALL have port busy, output, 1, high from accepted start until done.
REQ-010 SHALL have port done, output, 1, high after the last result is accepted; held until the next accepted start.
REQ-011 SHALL have port result_valid, output, 1, result fields are valid.
REQ-012 SHALL have port result_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port result_bin, output, 3, bin number 1..7.
REQ-014 SHALL have port result_count, output, 19, pixels labelled with result_bin.
REQ-015 SHALL have port result_sum_x, output, 28, sum of x over those pixels.
REQ-016 SHALL have port result_sum_y, output, 28, sum of y over those pixels.

Function
REQ-017 SHALL implement states IDLE, SCAN, DRAIN, EMIT, DONE.
REQ-018 IDLE/DONE: start=1 SHALL clear all 7 accumulators, set bram_addr=0, x=0, y=0, busy=1, done=0, and enter SCAN.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SCAN SHALL advance bram_addr by 1 every cycle; x wraps at WIDTH-1 to 0 and then y increments.
REQ-021 SHALL carry x,y through a READ_LATENCY-deep pipeline aligned with the returning bram_read.
REQ-022 A returned label b in 1..7 SHALL add 1 to count[b], x to sum_x[b], and y to sum_y[b]; b=0 SHALL change nothing.
REQ-023 After issuing address WIDTH*HEIGHT-1, SHALL enter DRAIN for READ_LATENCY cycles so the last sample is accumulated, then enter EMIT.
REQ-024 EMIT SHALL present bins 1..7 in ascending order; a result completes on a cycle with result_valid and result_ready both high.
REQ-025 Result fields SHALL remain stable while result_valid=1 and result_ready=0.
REQ-026 Result_valid SHALL not depend combinationally on result_ready.
REQ-027 After bin 7 is accepted, SHALL enter DONE with done=1, busy=0, result_valid=0.
REQ-028 Accumulator widths SHALL not overflow for a full frame (max count 307200, max sum_x 98150400).
REQ-029 Full scan-to-first-valid latency SHALL be WIDTH*HEIGHT+READ_LATENCY+1 cycles after start.

Reset
REQ-030 Reset SHALL force IDLE immediately, including mid-SCAN or mid-EMIT, with bram_addr=0, busy=0, done=0, result_valid=0, result_bin=0, result_count=0, result_sum_x=0, result_sum_y=0, and all accumulators cleared.

Structure
REQ-031 WIDTH, HEIGHT, the bin-label width (3), and the bin count (7) SHALL live in the shared video constants package used by the contour writer.
REQ-032 The module SHALL contain one sub-module, bin_accumulator, that holds the 7-entry count/sum register file with clear, add, and read ports.

Verification
REQ-033 All-zero BRAM, start -> seven results, bins 1..7, each count=0, sum_x=0, sum_y=0, then done=1.
REQ-034 Single label 3 at addr 12810 (x=10, y=20) -> bin3 gives count=1, sum_x=10, sum_y=20; all other bins give 0.
REQ-035 Full frame labelled 7 -> bin7 gives count=307200, sum_x=98150400, sum_y=73574400.
REQ-036 result_ready held low 5 cycles during bin1 -> bin1 fields stable, no bin skipped, bin2 follows acceptance.
REQ-037 Reset asserted at addr 1000 mid-SCAN, then a new start -> results reflect only the new frame.
REQ-038 Second start pulse during SCAN -> ignored; the scan completes normally with unchanged results.
